// File: rtl/log_sched_pkg.sv
// Shared sizing, FSM states and lane geometry for the river-log spawn scheduler.
package log_sched_pkg;

   localparam int unsigned NUM_LANES     = 5;
   localparam int unsigned LOGS_PER_LANE = 3;
   localparam int unsigned NUM_LOGS      = NUM_LANES * LOGS_PER_LANE;
   localparam int unsigned BASE_GAP      = 8;
   localparam int unsigned LANE_Y0       = 64;
   localparam int unsigned LANE_PITCH    = 32;
   localparam int unsigned X_LEFT        = 0;
   localparam int unsigned X_RIGHT       = 448;
   localparam int unsigned X_PRIME       = 200;

   localparam int unsigned LANE_W = 3;
   localparam int unsigned SLOT_W = 4;
   localparam int unsigned KW     = 2;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned XY_W   = 9;
   localparam int unsigned RND_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   function automatic logic [XY_W-1:0] lane_y(input logic [LANE_W-1:0] lane);
      return XY_W'(LANE_Y0 + 32'(lane) * LANE_PITCH);
   endfunction

   // Even lanes enter from the left edge, odd lanes from the right.
   function automatic logic [XY_W-1:0] lane_x(input logic [LANE_W-1:0] lane);
      return lane[0] ? XY_W'(X_RIGHT) : XY_W'(X_LEFT);
   endfunction

   function automatic logic [SLOT_W-1:0] slot_of(input logic [LANE_W-1:0] lane,
                                                 input logic [KW-1:0]     k);
      return SLOT_W'(32'(lane) * LOGS_PER_LANE + 32'(k));
   endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// Combinational round-robin pick: first requesting lane at or after the pointer.
module lane_rr_arbiter
   import log_sched_pkg::*;
(
   input  logic [NUM_LANES-1:0] i_req,
   input  logic [LANE_W-1:0]    i_ptr,
   output logic                 o_grant_valid_c,
   output logic [LANE_W-1:0]    o_grant_idx_c
);

   int unsigned w_idx;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      o_grant_valid_c = 1'b0;
      o_grant_idx_c   = '0;
      w_idx           = 0;
      for (int off = NUM_LANES - 1; off >= 0; off--) begin
         w_idx = (32'(i_ptr) + 32'(off)) % NUM_LANES;
         if (i_req[w_idx]) begin
            o_grant_valid_c = 1'b1;
            o_grant_idx_c   = LANE_W'(w_idx);
         end
      end
   end

endmodule

// File: rtl/log_spawn_scheduler.sv
// Decides when each river-log slot is enabled and which start X/Y it loads:
// per-lane spawn countdowns feeding a one-grant-per-clock round-robin arbiter.
module log_spawn_scheduler
   import log_sched_pkg::*;
(
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic                               start,
   input  logic                               stop,
   input  logic                               timer_done,
   input  logic [RND_W-1:0]                   random_0_15,
   input  logic [NUM_LOGS-1:0]                log_exited,
   output logic [NUM_LOGS-1:0]                enable,
   output logic [NUM_LOGS-1:0][XY_W-1:0]      start_offsetY,
   output logic [NUM_LOGS-1:0][XY_W-1:0]      start_offsetX,
   output logic                               spawn_pulse,
   output logic [SLOT_W-1:0]                  spawn_slot,
   output logic                               busy
);

   state_t                          r_state, w_state_nxt;
   logic [LANE_W-1:0]               r_lane_idx, w_lane_nxt;
   logic [LANE_W-1:0]               r_rr, w_rr_nxt;
   logic [NUM_LANES-1:0][CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [NUM_LOGS-1:0]             r_enable, w_en_nxt;
   logic [NUM_LOGS-1:0][XY_W-1:0]   r_offx, w_offx_nxt, r_offy, w_offy_nxt;
   logic                            r_pulse, w_pulse_nxt, r_busy;
   logic [SLOT_W-1:0]               r_slot, w_slot_nxt;

   logic [NUM_LANES-1:0]            w_has_free, w_req;
   logic [NUM_LANES-1:0][KW-1:0]    w_free_k;
   logic                            w_gnt_valid;
   logic [LANE_W-1:0]               w_gnt_idx;
   logic                            w_do_spawn;
   logic [LANE_W-1:0]               w_sp_lane;
   logic [SLOT_W-1:0]               w_sp_slot;
   logic [XY_W-1:0]                 w_sp_x;

   // Lowest free slot per lane; exits this cycle are not yet visible here.
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         w_has_free[l] = 1'b0;
         w_free_k[l]   = '0;
         for (int k = LOGS_PER_LANE - 1; k >= 0; k--) begin
            if (!r_enable[l*LOGS_PER_LANE + k]) begin
               w_has_free[l] = 1'b1;
               w_free_k[l]   = KW'(k);
            end
         end
         w_req[l] = w_has_free[l] && (r_cnt[l] == '0);
      end
   end

   lane_rr_arbiter u_arb (
      .i_req           (w_req),
      .i_ptr           (r_rr),
      .o_grant_valid_c (w_gnt_valid),
      .o_grant_idx_c   (w_gnt_idx)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_lane_nxt  = r_lane_idx;
      w_rr_nxt    = r_rr;
      w_cnt_nxt   = r_cnt;
      w_en_nxt    = r_enable;
      w_offx_nxt  = r_offx;
      w_offy_nxt  = r_offy;
      w_pulse_nxt = 1'b0;
      w_slot_nxt  = r_slot;
      w_do_spawn  = 1'b0;
      w_sp_lane   = '0;
      w_sp_slot   = '0;
      w_sp_x      = '0;

      if (r_state != ST_IDLE) w_en_nxt = r_enable & ~log_exited;

      case (r_state)
         ST_IDLE: begin
            if (start && !stop) begin
               w_state_nxt = ST_PRIME;
               w_lane_nxt  = '0;
            end
         end
         ST_PRIME: begin
            if (stop) begin
               w_state_nxt = ST_FLUSH;
            end else begin
               w_do_spawn = 1'b1;
               w_sp_lane  = r_lane_idx;
               w_sp_slot  = slot_of(r_lane_idx, KW'(0));
               w_sp_x     = XY_W'(X_PRIME);
               w_cnt_nxt[r_lane_idx] = CNT_W'(BASE_GAP) + CNT_W'(r_lane_idx);
               if (r_lane_idx == LANE_W'(NUM_LANES - 1)) w_state_nxt = ST_RUN;
               else                                       w_lane_nxt  = r_lane_idx + LANE_W'(1);
            end
         end
         ST_RUN: begin
            if (stop) begin
               w_state_nxt = ST_FLUSH;
            end else begin
               if (timer_done) begin
                  for (int l = 0; l < NUM_LANES; l++)
                     if (r_cnt[l] != '0) w_cnt_nxt[l] = r_cnt[l] - CNT_W'(1);
               end
               // A spawn reload overrides the tick decrement on the same lane.
               if (w_gnt_valid) begin
                  w_do_spawn = 1'b1;
                  w_sp_lane  = w_gnt_idx;
                  w_sp_slot  = slot_of(w_gnt_idx, w_free_k[w_gnt_idx]);
                  w_sp_x     = lane_x(w_gnt_idx);
                  w_cnt_nxt[w_gnt_idx] = CNT_W'(BASE_GAP) + CNT_W'(random_0_15);
                  w_rr_nxt = (w_gnt_idx == LANE_W'(NUM_LANES - 1)) ? '0
                                                                   : w_gnt_idx + LANE_W'(1);
               end
            end
         end
         ST_FLUSH: begin
            w_en_nxt    = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      if (w_do_spawn) begin
         w_en_nxt[w_sp_slot]   = 1'b1;
         w_offx_nxt[w_sp_slot] = w_sp_x;
         w_offy_nxt[w_sp_slot] = lane_y(w_sp_lane);
         w_pulse_nxt           = 1'b1;
         w_slot_nxt            = w_sp_slot;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state    <= ST_IDLE;
         r_lane_idx <= '0;
         r_rr       <= '0;
         r_cnt      <= '0;
         r_enable   <= '0;
         r_offx     <= '0;
         r_offy     <= '0;
         r_pulse    <= 1'b0;
         r_slot     <= '0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lane_idx <= w_lane_nxt;
         r_rr       <= w_rr_nxt;
         r_cnt      <= w_cnt_nxt;
         r_enable   <= w_en_nxt;
         r_offx     <= w_offx_nxt;
         r_offy     <= w_offy_nxt;
         r_pulse    <= w_pulse_nxt;
         r_slot     <= w_slot_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   assign enable        = r_enable;
   assign start_offsetX = r_offx;
   assign start_offsetY = r_offy;
   assign spawn_pulse   = r_pulse;
   assign spawn_slot    = r_slot;
   assign busy          = r_busy;

endmodule

// File: doc/log_spawn_scheduler.md
Name: log_spawn_scheduler

Overview:
Sequences the 15 river-log slots that feed the multi-log mover/draw path. Decides when each log slot is enabled and what start X/Y it loads. Logs are grouped into lanes, with per-lane spawn timers and a round-robin arbiter that grants one spawn per clock. Sits between the game-control FSM / tick timer and the bank of log movers.

Parameters:
NUM_LANES, 5, river lanes
LOGS_PER_LANE, 3, slots per lane; NUM_LOGS = NUM_LANES*LOGS_PER_LANE = 15
BASE_GAP, 8, minimum ticks between spawns in a lane (1..16)
LANE_Y0, 64, Y of lane 0
LANE_PITCH, 32, Y step per lane; LANE_Y0+(NUM_LANES-1)*LANE_PITCH must be ≤ 511
X_LEFT, 0, spawn X for even lanes
X_RIGHT, 448, spawn X for odd lanes
X_PRIME, 200, X used for initial population

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
start  in  1  pulse: begin round (honoured in IDLE only)
stop  in  1  pulse: end round, clear all logs
timer_done  in  1  one-cycle game tick
random_0_15  in  4  random gap extension
log_exited  in  15  per-slot pulse from mover: log left screen
enable  out  15  per-slot active flag to movers
start_offsetY  out  9 x 15  per-slot start Y
start_offsetX  out  9 x 15  per-slot start X
spawn_pulse  out  1  high for one cycle on each spawn
spawn_slot  out  4  slot index of current spawn, valid with spawn_pulse
busy  out  1  high in PRIME, RUN or FLUSH

Behaviour:
- Reset (async, any state): enable=0, all offsets=0, spawn_pulse=0, spawn_slot=0, countdowns=0, rr_ptr=0, state=IDLE.
- Slot index = lane*LOGS_PER_LANE + k. Lane Y = LANE_Y0 + lane*LANE_PITCH. Free slot = lowest k with enable bit 0.
- Spawn (a registered action on one edge): enable[slot] set, start_offsetX[slot] and start_offsetY[slot] written on the same edge, spawn_pulse=1, spawn_slot=slot. Offsets hold after enable clears.
- IDLE: all outputs hold. start=1 and stop=0 → PRIME with lane_idx=0. If start and stop are both high, stop wins and the block stays in IDLE.
- PRIME: one lane per cycle. Spawn slot k=0 of lane_idx with X=X_PRIME. countdown[lane] = BASE_GAP + lane (stagger). After the last lane → RUN. PRIME therefore takes exactly NUM_LANES cycles.
- RUN:
  - On timer_done, each nonzero countdown decrements by 1. A countdown at 0 stays at 0 (saturating).
  - pending[L] = (countdown[L]==0) AND (lane L has a free slot).
  - Arbiter: starting at rr_ptr, pick the first pending lane and spawn it. X is X_LEFT for an even lane, X_RIGHT for an odd lane.
  - On a spawn: countdown[L] = BASE_GAP + random_0_15 (5-bit, max 31); rr_ptr = (L+1) mod NUM_LANES.
  - At most one spawn per cycle. Other pending lanes wait; they get no extra decrement.
  - A lane at 0 with no free slot stays at 0 and spawns the cycle after a slot frees.
- log_exited[i] clears enable[i] on the next edge (all states except IDLE). A pulse on an already-clear slot is ignored. The freed slot is not visible to the arbiter in the same cycle.
- Simultaneous timer_done and spawn on a lane: the reload wins over the decrement.
- stop in PRIME or RUN → FLUSH. On that edge no spawn occurs. FLUSH clears enable and all countdowns in one cycle, then goes to IDLE. start is ignored outside IDLE.
- spawn_pulse is 0 in every cycle without a spawn.
- Latency: a timer_done that takes a countdown from 1 to 0 at edge N allows a spawn at edge N+1 at the earliest.

Decomposition:
- Package log_sched_pkg holds:
  - NUM_LANES, LOGS_PER_LANE, NUM_LOGS
  - the state enum {IDLE, PRIME, RUN, FLUSH}
  - lane-geometry functions lane_y(L) and lane_x(L)
- Sub-module lane_rr_arbiter: NUM_LANES-wide request vector and rr_ptr in; grant valid and grant index out; purely combinational.

Test Plan:
- Assert RESET mid-RUN with enable=15'h7FFF → next cycle enable=0, offsets=0, busy=0; after release, a start pulse restarts PRIME.
- start in IDLE → 5 consecutive spawn_pulse cycles on slots 0,3,6,9,12, each with X=200 and Y=64,96,128,160,192; then state RUN.
- Force random_0_15=0 and pulse timer_done 8 times → lane 0 spawns slot 1 with X=0, Y=64, and its countdown reloads to 8.
- Lanes 1 and 3 reach 0 on the same tick with rr_ptr=2 → lane 3 spawns first (slot 10, X=448), then lane 1 on the next cycle; rr_ptr ends at 2.
- Lane 2 has all 3 slots full and countdown=0 → no spawn; pulse log_exited[7] → enable[7] clears, then one cycle later slot 7 respawns with X=0, Y=128.
- stop asserted on the same cycle as a pending spawn → no spawn, enable=0 after FLUSH, then IDLE; start+stop together in IDLE → remains IDLE.
